// File: rtl/cpu_pkg.sv
// Datapath-wide sizing shared by the register file and the issue controller.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 16;
  localparam int unsigned CPU_ADDR_W = 4;

  typedef logic [CPU_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: write-first bypass, optional zero register, output flop.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic is_zero;
  logic bypass;

  always_comb begin
    is_zero = (ZERO_REG != 0) && (rd_addr == '0);
    bypass  = wr_en && (wr_addr == rd_addr);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rd_data <= '0;
    end else if (rd_en) begin
      // zero register overrides even a same-cycle write to r0
      if (is_zero)
        rd_data <= '0;
      else if (bypass)
        rd_data <= wr_data;
      else
        rd_data <= reg_data;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy scoreboard and RAW stall flag.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  output logic [DEPTH-1:0]      busy,
  output logic                  stall
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_next;
  logic              wr_ok;

  always_comb begin
    wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // issue is applied after retire so a same-address pair leaves the register busy
  always_comb begin
    busy_next = busy;
    if (wr_en)
      busy_next[wr_addr] = 1'b0;
    if (issue_en)
      busy_next[issue_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (clear)
      busy <= '0;
    else
      busy <= busy_next;
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    stall = 1'b0;
    a     = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      a = rd_addr[p*ADDR_W +: ADDR_W];
      if (rd_en[p] && busy[a] && !(wr_en && (wr_addr == a))
          && !((ZERO_REG != 0) && (a == '0)))
        stall = 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clock    (clock),
      .clear    (clear),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .reg_data (regs[rd_addr[p*ADDR_W +: ADDR_W]]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one instance without and one with the hard-wired zero register, shared stimulus.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        clear;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        issue_en;
  logic [3:0]  issue_addr;

  logic [31:0] rd_data_a, rd_data_z;
  logic [15:0] busy_a, busy_z;
  logic        stall_a, stall_z;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_scoreboard #(
    .DATA_W(16), .DEPTH(16), .ADDR_W(4), .NRD(2), .ZERO_REG(0)
  ) dut_a (
    .clock(clock), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy(busy_a), .stall(stall_a)
  );

  regfile_scoreboard #(
    .DATA_W(16), .DEPTH(16), .ADDR_W(4), .NRD(2), .ZERO_REG(1)
  ) dut_z (
    .clock(clock), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy(busy_z), .stall(stall_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; rd_en = 2'b00; rd_addr = 8'h00;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 16'h0000;
    issue_en = 1'b0; issue_addr = 4'h0;
  endtask

  initial begin
    idle();
    clear = 1'b1;
    tick();
    idle();

    // 1: populate state, then clear while a write and an issue are also requested
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hAAAA; tick();
    wr_addr = 4'd1; wr_data = 16'h1111; issue_en = 1'b1; issue_addr = 4'd2; tick();
    idle(); rd_en = 2'b11; rd_addr = {4'd1, 4'd5}; tick();
    idle();
    clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555;
    issue_en = 1'b1; issue_addr = 4'd6;
    tick();
    idle(); #1;
    chk("clr_rd_a",    rd_data_a, 32'h0);
    chk("clr_rd_z",    rd_data_z, 32'h0);
    chk("clr_busy_a",  {16'h0, busy_a}, 32'h0);
    chk("clr_busy_z",  {16'h0, busy_z}, 32'h0);
    chk("clr_stall_a", {31'h0, stall_a}, 32'h0);
    rd_en = 2'b01; rd_addr = {4'd0, 4'd5}; tick();
    idle();
    chk("clr_r5_a", rd_data_a, 32'h0);
    chk("clr_r5_z", rd_data_z, 32'h0);

    // 2: write then dual read
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; tick();
    idle(); rd_en = 2'b11; rd_addr = {4'd3, 4'd3}; tick();
    idle();
    chk("r3_both_a", rd_data_a, 32'hBEEF_BEEF);
    chk("r3_both_z", rd_data_z, 32'hBEEF_BEEF);

    // 3: bypass on port 1, port 0 disabled holds
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
    rd_en = 2'b10; rd_addr = {4'd7, 4'd0}; tick();
    idle();
    chk("bypass_a", rd_data_a, 32'h1234_BEEF);
    chk("bypass_z", rd_data_z, 32'h1234_BEEF);

    // 4: RAW hazard, released by same-cycle write
    issue_en = 1'b1; issue_addr = 4'd4; tick();
    idle();
    chk("issue4_busy", {16'h0, busy_a}, 32'h0000_0010);
    rd_en = 2'b01; rd_addr = {4'd0, 4'd4}; #1;
    chk("raw_stall_a", {31'h0, stall_a}, 32'h1);
    chk("raw_stall_z", {31'h0, stall_z}, 32'h1);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0042; #1;
    chk("raw_release", {31'h0, stall_a}, 32'h0);
    tick();
    idle();
    chk("r4_busy_clr", {16'h0, busy_a}, 32'h0);
    chk("r4_data",     {16'h0, rd_data_a[15:0]}, 32'h0042);

    // 5: issue and retire same register, issue wins; later retire clears
    issue_en = 1'b1; issue_addr = 4'd9; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0999; tick();
    idle();
    chk("r9_issue_wins", {16'h0, busy_a}, 32'h0000_0200);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0998; tick();
    idle();
    chk("r9_retire", {16'h0, busy_z}, 32'h0);

    // WAW: double issue stays busy, one retire clears
    issue_en = 1'b1; issue_addr = 4'd2; tick();
    tick();
    idle();
    chk("waw_busy", {16'h0, busy_a}, 32'h0000_0004);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222; tick();
    idle();
    chk("waw_retire", {16'h0, busy_a}, 32'h0);

    // 6: register 0 behaviour with and without zero register
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; issue_en = 1'b1; issue_addr = 4'd0; tick();
    idle();
    chk("r0_busy_a", {16'h0, busy_a}, 32'h0000_0001);
    chk("r0_busy_z", {16'h0, busy_z}, 32'h0);
    rd_en = 2'b01; rd_addr = {4'd0, 4'd0}; #1;
    chk("r0_stall_a", {31'h0, stall_a}, 32'h1);
    chk("r0_stall_z", {31'h0, stall_z}, 32'h0);
    tick();
    idle();
    chk("r0_rd_a", {16'h0, rd_data_a[15:0]}, 32'hFFFF);
    chk("r0_rd_z", {16'h0, rd_data_z[15:0]}, 32'h0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1357;
    rd_en = 2'b10; rd_addr = {4'd0, 4'd0}; tick();
    idle();
    chk("r0_byp_a", {16'h0, rd_data_a[31:16]}, 32'h1357);
    chk("r0_byp_z", {16'h0, rd_data_z[31:16]}, 32'h0);
    chk("r0_ret_a", {16'h0, busy_a}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
